// File: rtl/rom_seq_reader_pkg.sv
// Shared types and sizes for the ROM sequential reader.
// Sizes, FSM state encoding and a sweep-length helper.
package rom_seq_reader_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int SUM_W  = DATA_W + ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bytes in an inclusive, wrapping range.
  function automatic logic [ADDR_W:0] sweep_len(
    input logic [ADDR_W-1:0] first,
    input logic [ADDR_W-1:0] last
  );
    logic [ADDR_W-1:0] d;
    d = last - first;
    return {1'b0, d} + (ADDR_W+1)'(1);
  endfunction

endpackage

// File: rtl/rom_seq_reader.sv
// Sweeps an inclusive, wrapping ROM address range and streams bytes.
// Ports: clk/rst_n, start/abort, first_addr/last_addr, rom_addr/rom_rd_en/
// rom_data, out_data/out_valid/out_ready, sum, busy, done.
module rom_seq_reader #(
  parameter int ADDR_W = rom_seq_reader_pkg::ADDR_W,
  parameter int DATA_W = rom_seq_reader_pkg::DATA_W,
  parameter int SUM_W  = rom_seq_reader_pkg::SUM_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rd_en,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  sum,
  output logic              busy,
  output logic              done
);

  import rom_seq_reader_pkg::*;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] last_q;
  logic [DATA_W-1:0] data_q;
  logic [SUM_W-1:0]  sum_q;
  logic              hs;
  logic              at_last;

  assign hs      = (state == HOLD) && out_ready;
  assign at_last = (addr_q == last_q);

  always_comb begin
    state_nx  = state;
    rom_rd_en = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = FETCH;
      end
      FETCH: begin
        rom_rd_en = 1'b1;
        busy      = 1'b1;
        state_nx  = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (hs) state_nx = at_last ? DONE : FETCH;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Cancel overrides every other transition.
    if (abort) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      addr_q <= '0;
      last_q <= '0;
      data_q <= '0;
      sum_q  <= '0;
    end else begin
      state <= state_nx;
      if (!abort) begin
        unique case (state)
          IDLE: begin
            if (start) begin
              addr_q <= first_addr;
              last_q <= last_addr;
              sum_q  <= '0;
            end
          end
          FETCH: begin
            data_q <= rom_data;
            sum_q  <= sum_q + {{(SUM_W-DATA_W){1'b0}}, rom_data};
          end
          HOLD: begin
            if (hs && !at_last) addr_q <= addr_q + ADDR_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign rom_addr = addr_q;
  assign out_data = data_q;
  assign sum      = sum_q;

endmodule

// File: tb/tb_rom_seq_reader.sv
// Directed bench for rom_seq_reader with an inline 16x8 ROM model.
// ROM word i holds 8'h10 + i.
module tb_rom_seq_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] first_addr = '0;
  logic [3:0] last_addr = '0;
  logic [3:0] rom_addr;
  logic       rom_rd_en;
  logic [7:0] rom_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic [11:0] sum;
  logic       busy;
  logic       done;

  logic [7:0] rom_mem [16];

  int checks = 0;
  int errors = 0;

  logic [7:0] got_bytes[$];
  logic [3:0] got_addrs[$];

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 16; i++) rom_mem[i] = 8'h10 + 8'(i);
  end

  assign rom_data = rom_rd_en ? rom_mem[rom_addr] : 8'h00;

  rom_seq_reader dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .first_addr(first_addr),
    .last_addr(last_addr),
    .rom_addr(rom_addr),
    .rom_rd_en(rom_rd_en),
    .rom_data(rom_data),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum(sum),
    .busy(busy),
    .done(done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one sweep and records what it observes; no comparisons here.
  // Cycle 1 is the FETCH cycle right after the start edge.
  task automatic run_sweep(
    input  logic [3:0] f,
    input  logic [3:0] l,
    output int         done_cyc,
    output int         dones,
    output int         rd_cnt,
    output bit         timeout
  );
    int cyc;
    got_bytes.delete();
    got_addrs.delete();
    done_cyc = -1;
    dones = 0;
    rd_cnt = 0;
    first_addr = f;
    last_addr = l;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    while (cyc < 100) begin
      if (rom_rd_en) begin
        rd_cnt++;
        got_addrs.push_back(rom_addr);
      end
      if (out_valid && out_ready) got_bytes.push_back(out_data);
      if (done) begin
        dones++;
        done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      step();
      cyc++;
    end
    timeout = (done_cyc < 0);
  endtask

  task automatic test_reset();
    #2;
    checks++; if (rom_addr !== 4'h0) begin errors++; $display("FAIL reset_rom_addr: got %h expected %h", rom_addr, 4'h0); end
    checks++; if (rom_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected %b", rom_rd_en, 1'b0); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected %h", out_data, 8'h00); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected %b", out_valid, 1'b0); end
    checks++; if (sum !== 12'h000) begin errors++; $display("FAIL reset_sum: got %h expected %h", sum, 12'h000); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected %b", busy, 1'b0); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected %b", done, 1'b0); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected %b", busy, 1'b0); end
  endtask

  task automatic test_basic();
    logic [7:0] exp_b [4];
    int dc, dn, rc;
    bit to;
    exp_b = '{8'h10, 8'h11, 8'h12, 8'h13};
    out_ready = 1'b1;
    run_sweep(4'd0, 4'd3, dc, dn, rc, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout: got %b expected %b", to, 1'b0); end
    checks++; if (got_bytes.size() !== 4) begin errors++; $display("FAIL basic_count: got %0d expected %0d", got_bytes.size(), 4); end
    for (int i = 0; i < 4 && i < got_bytes.size(); i++) begin
      checks++; if (got_bytes[i] !== exp_b[i]) begin errors++; $display("FAIL basic_byte%0d: got %h expected %h", i, got_bytes[i], exp_b[i]); end
    end
    checks++; if (sum !== 12'h046) begin errors++; $display("FAIL basic_sum: got %h expected %h", sum, 12'h046); end
    checks++; if (dc !== 9) begin errors++; $display("FAIL basic_done_cycle: got %0d expected %0d", dc, 9); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL basic_done_count: got %0d expected %0d", dn, 1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b expected %b", busy, 1'b0); end
    step();
    step();
    checks++; if (sum !== 12'h046) begin errors++; $display("FAIL basic_sum_hold: got %h expected %h", sum, 12'h046); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_b [4];
    logic [3:0] exp_a [4];
    int dc, dn, rc;
    bit to;
    exp_b = '{8'h1E, 8'h1F, 8'h10, 8'h11};
    exp_a = '{4'd14, 4'd15, 4'd0, 4'd1};
    out_ready = 1'b1;
    run_sweep(4'd14, 4'd1, dc, dn, rc, to);
    checks++; if (got_bytes.size() !== 4) begin errors++; $display("FAIL wrap_count: got %0d expected %0d", got_bytes.size(), 4); end
    checks++; if (got_addrs.size() !== 4) begin errors++; $display("FAIL wrap_addr_count: got %0d expected %0d", got_addrs.size(), 4); end
    for (int i = 0; i < 4 && i < got_bytes.size(); i++) begin
      checks++; if (got_bytes[i] !== exp_b[i]) begin errors++; $display("FAIL wrap_byte%0d: got %h expected %h", i, got_bytes[i], exp_b[i]); end
    end
    for (int i = 0; i < 4 && i < got_addrs.size(); i++) begin
      checks++; if (got_addrs[i] !== exp_a[i]) begin errors++; $display("FAIL wrap_addr%0d: got %0d expected %0d", i, got_addrs[i], exp_a[i]); end
    end
    checks++; if (sum !== 12'h05E) begin errors++; $display("FAIL wrap_sum: got %h expected %h", sum, 12'h05E); end
    checks++; if (dc !== 9) begin errors++; $display("FAIL wrap_done_cycle: got %0d expected %0d", dc, 9); end
  endtask

  task automatic test_full();
    logic [7:0] e;
    int dc, dn, rc;
    bit to;
    out_ready = 1'b1;
    run_sweep(4'd5, 4'd4, dc, dn, rc, to);
    checks++; if (got_bytes.size() !== 16) begin errors++; $display("FAIL full_count: got %0d expected %0d", got_bytes.size(), 16); end
    for (int i = 0; i < 16 && i < got_bytes.size(); i++) begin
      e = 8'h10 + 8'((5 + i) % 16);
      checks++; if (got_bytes[i] !== e) begin errors++; $display("FAIL full_byte%0d: got %h expected %h", i, got_bytes[i], e); end
    end
    checks++; if (sum !== 12'h178) begin errors++; $display("FAIL full_sum: got %h expected %h", sum, 12'h178); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL full_done_count: got %0d expected %0d", dn, 1); end
    checks++; if (rc !== 16) begin errors++; $display("FAIL full_rd_en_cycles: got %0d expected %0d", rc, 16); end
    checks++; if (dc !== 33) begin errors++; $display("FAIL full_done_cycle: got %0d expected %0d", dc, 33); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    first_addr = 4'd2;
    last_addr = 4'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (rom_rd_en !== 1'b1) begin errors++; $display("FAIL bp_fetch_rd_en: got %b expected %b", rom_rd_en, 1'b1); end
    step();
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid%0d: got %b expected %b", i, out_valid, 1'b1); end
      checks++; if (out_data !== 8'h12) begin errors++; $display("FAIL bp_data%0d: got %h expected %h", i, out_data, 8'h12); end
      checks++; if (rom_rd_en !== 1'b0) begin errors++; $display("FAIL bp_rd_en%0d: got %b expected %b", i, rom_rd_en, 1'b0); end
      if (i < 4) step();
    end
    out_ready = 1'b1;
    step();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done: got %b expected %b", done, 1'b1); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_after: got %b expected %b", out_valid, 1'b0); end
    checks++; if (sum !== 12'h012) begin errors++; $display("FAIL bp_sum: got %h expected %h", sum, 12'h012); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy_after: got %b expected %b", busy, 1'b0); end
  endtask

  task automatic test_abort_restart();
    int dc, dn, rc;
    bit to;
    bit saw_done;
    out_ready = 1'b1;
    first_addr = 4'd0;
    last_addr = 4'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    first_addr = 4'd9;
    last_addr = 4'd9;
    step();
    start = 1'b0;
    checks++; if (rom_addr !== 4'd1) begin errors++; $display("FAIL abort_busy_start_addr: got %0d expected %0d", rom_addr, 1); end
    step();
    checks++; if (out_data !== 8'h11) begin errors++; $display("FAIL abort_hold_data: got %h expected %h", out_data, 8'h11); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected %b", busy, 1'b0); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b expected %b", out_valid, 1'b0); end
    checks++; if (sum !== 12'h021) begin errors++; $display("FAIL abort_sum: got %h expected %h", sum, 12'h021); end
    saw_done = done;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b expected %b", saw_done, 1'b0); end
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle_start: got %b expected %b", busy, 1'b0); end
    run_sweep(4'd9, 4'd9, dc, dn, rc, to);
    checks++; if (got_bytes.size() !== 1) begin errors++; $display("FAIL restart_count: got %0d expected %0d", got_bytes.size(), 1); end
    if (got_bytes.size() > 0) begin
      checks++; if (got_bytes[0] !== 8'h19) begin errors++; $display("FAIL restart_byte: got %h expected %h", got_bytes[0], 8'h19); end
    end
    checks++; if (sum !== 12'h019) begin errors++; $display("FAIL restart_sum: got %h expected %h", sum, 12'h019); end
    checks++; if (dc !== 3) begin errors++; $display("FAIL restart_done_cycle: got %0d expected %0d", dc, 3); end
  endtask

  task automatic test_async_reset();
    int dc, dn, rc;
    bit to;
    out_ready = 1'b1;
    first_addr = 4'd0;
    last_addr = 4'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    checks++; if (rom_rd_en !== 1'b1) begin errors++; $display("FAIL ar_pre_rd_en: got %b expected %b", rom_rd_en, 1'b1); end
    checks++; if (sum !== 12'h010) begin errors++; $display("FAIL ar_pre_sum: got %h expected %h", sum, 12'h010); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (rom_addr !== 4'h0) begin errors++; $display("FAIL ar_rom_addr: got %h expected %h", rom_addr, 4'h0); end
    checks++; if (rom_rd_en !== 1'b0) begin errors++; $display("FAIL ar_rd_en: got %b expected %b", rom_rd_en, 1'b0); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL ar_out_data: got %h expected %h", out_data, 8'h00); end
    checks++; if (sum !== 12'h000) begin errors++; $display("FAIL ar_sum: got %h expected %h", sum, 12'h000); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_busy: got %b expected %b", busy, 1'b0); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b expected %b", out_valid, 1'b0); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_idle: got %b expected %b", busy, 1'b0); end
    run_sweep(4'd3, 4'd3, dc, dn, rc, to);
    checks++; if (sum !== 12'h013) begin errors++; $display("FAIL ar_restart_sum: got %h expected %h", sum, 12'h013); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL ar_restart_done: got %0d expected %0d", dn, 1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_full();
    test_backpressure();
    test_abort_restart();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
